// File: rtl/apb_multi_slave_top_if.sv
// ---------------------------------------------------------------------------
// apb_multi_slave_top_if
// Command/response port of apb_multi_slave_top plus the APB observation
// signals.
//   req_valid/req_write/req_addr/req_wdata : request from requester
//   req_ready                              : subsystem idle, request accepted
//   rsp_valid/rsp_rdata/rsp_err            : one-cycle completion report
//   psel/penable/pready                    : APB observation outputs
// Modports: master = requester side, slave = subsystem side.
// ---------------------------------------------------------------------------
interface apb_multi_slave_top_if #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_SLAVES = 4
);
    logic                  req_valid;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  req_ready;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic [NUM_SLAVES-1:0] psel;
    logic                  penable;
    logic                  pready;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pready
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pready
    );
endinterface

// File: rtl/apb_multi_slave_top.sv
// ---------------------------------------------------------------------------
// apb_multi_slave_top
// Request-driven APB master, address decoder and NUM_SLAVES register-file
// slaves in one block. Each accepted request becomes one SETUP + ACCESS
// transfer; out-of-range addresses complete in the first ACCESS cycle with
// PSLVERR.
// Ports:
//   pclk   : clock, rising edge
//   preset : asynchronous active-high reset (clears FSM and all arrays)
//   bus    : apb_multi_slave_top_if.slave (request/response + observation)
// Build option:
//   APB_WAIT_STATE_EN : when defined, in-range transfers insert WAIT_CYCLES
//                       ACCESS wait states using a shared counter; when
//                       undefined, pready is high in every ACCESS cycle.
// DEPTH must be a power of 2 and at least 2.
// ---------------------------------------------------------------------------
module apb_multi_slave_top #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned NUM_SLAVES  = 4,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic                  pclk,
    input logic                  preset,
    apb_multi_slave_top_if.slave bus
);
    localparam int unsigned OFF_W = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    logic [ADDR_W-1:0]     slv_idx;
    logic [OFF_W-1:0]      offset;
    logic                  in_range;
    logic [NUM_SLAVES-1:0] sel_dec;
    logic                  access;
    logic                  wait_done;
    logic                  pready;
    logic                  done;
    logic [DATA_W-1:0]     prdata;
    logic [DATA_W-1:0]     slv_rdata [NUM_SLAVES];

    // Decode of the registered address.
    assign slv_idx  = addr_q >> OFF_W;
    assign offset   = addr_q[OFF_W-1:0];
    assign in_range = slv_idx < ADDR_W'(NUM_SLAVES);
    assign access   = (state_q == StAccess);

`ifdef APB_WAIT_STATE_EN
    logic [3:0] count_q;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            count_q <= '0;
        end else begin
            count_q <= access ? count_q + 4'd1 : 4'd0;
        end
    end

    assign wait_done = (count_q == 4'(WAIT_CYCLES));
`else
    // Wait states compiled out; keep the parameter referenced.
    logic unused_wait_cfg;
    assign unused_wait_cfg = ^4'(WAIT_CYCLES);
    assign wait_done       = 1'b1;
`endif

    // Out-of-range transfers complete immediately with an error.
    assign pready = access && (!in_range || wait_done);
    assign done   = access && pready;

    // Register-file slaves.
    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slave
        logic [DATA_W-1:0] mem_q [DEPTH];

        assign sel_dec[g] = in_range && (slv_idx == ADDR_W'(g));

        always_ff @(posedge pclk or posedge preset) begin
            if (preset) begin
                mem_q <= '{default: '0};
            end else if (sel_dec[g] && done && write_q) begin
                mem_q[offset] <= wdata_q;
            end
        end

        assign slv_rdata[g] = sel_dec[g] ? mem_q[offset] : '0;
    end

    // At most one slave is selected, so an OR acts as the read mux.
    always_comb begin
        prdata = '0;
        for (int unsigned s = 0; s < NUM_SLAVES; s++) begin
            prdata = prdata | slv_rdata[s];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (bus.req_valid) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (pready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= done;
            if (state_q == StIdle && bus.req_valid) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                write_q <= bus.req_write;
            end
            if (done) begin
                rsp_rdata_q <= (write_q || !in_range) ? '0 : prdata;
                rsp_err_q   <= !in_range;
            end
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.psel      = (state_q == StIdle) ? '0 : sel_dec;
    assign bus.penable   = access;
    assign bus.pready    = pready;
endmodule

// File: tb/tb_apb_multi_slave_top.sv
// ---------------------------------------------------------------------------
// tb_apb_multi_slave_top
// Directed bench for apb_multi_slave_top: reset, write/read, error decode,
// slave isolation, back-to-back requests and busy hold. Latency expectations
// follow APB_WAIT_STATE_EN (W=2 when defined, 0 otherwise).
// ---------------------------------------------------------------------------
module tb_apb_multi_slave_top;
`ifdef APB_WAIT_STATE_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif
    localparam int LAT = 3 + W;

    logic pclk   = 1'b0;
    logic preset = 1'b1;
    int   cyc    = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    apb_multi_slave_top_if #(.ADDR_W(8), .DATA_W(8), .NUM_SLAVES(4)) bus ();

    apb_multi_slave_top #(
        .ADDR_W(8), .DATA_W(8), .NUM_SLAVES(4), .DEPTH(16), .WAIT_CYCLES(2)
    ) dut (
        .pclk  (pclk),
        .preset(preset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 1);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        check({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 0);
        check({tag, "_rsp_err"},   32'(bus.rsp_err),   0);
        check({tag, "_psel"},      32'(bus.psel),      0);
        check({tag, "_penable"},   32'(bus.penable),   0);
        check({tag, "_pready"},    32'(bus.pready),    0);
    endtask

    // One complete transfer, driven and sampled on negedges.
    task automatic xfer(input string tag, input logic wr, input logic [7:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd, input logic exp_err,
                        input logic [3:0] exp_sel, input int exp_lat);
        int t0;
        bit ok;
        bit sel_bad;
        t0 = 0;
        ok = 0;
        sel_bad = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge pclk);
            bus.req_valid = 1'b1;
            bus.req_write = wr;
            bus.req_addr  = a;
            bus.req_wdata = d;
            if (bus.req_ready) begin
                ok = 1;
                t0 = cyc;
            end
        end
        if (!ok) begin
            bus.req_valid = 1'b0;
            check({tag, "_accept_timeout"}, 0, 1);
            return;
        end
        @(negedge pclk);
        bus.req_valid = 1'b0;
        check({tag, "_setup_psel"}, 32'(bus.psel), 32'(exp_sel));
        check({tag, "_setup_pen_prdy"}, {30'd0, bus.penable, bus.pready}, 0);
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge pclk);
            if (bus.rsp_valid) ok = 1;
            else if (bus.psel !== exp_sel) sel_bad = 1;
        end
        if (!ok) begin
            check({tag, "_rsp_timeout"}, 0, 1);
            return;
        end
        check({tag, "_psel_hold"}, 32'(sel_bad), 0);
        check({tag, "_latency"}, 32'(cyc - t0), 32'(exp_lat));
        check({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(exp_rd));
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_c [4];
        int rsp_c [4];
        int na;
        int nr;
        int t_a;
        int t_b;
        int pulses;
        bit b_acc;
        logic [7:0] b2b_addr [4];
        logic [7:0] b2b_data [4];

        b2b_addr = '{8'h06, 8'h16, 8'h26, 8'h36};
        b2b_data = '{8'h61, 8'h62, 8'h63, 8'h64};
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        // Power-on reset.
        repeat (2) @(negedge pclk);
        check_reset_outputs("por");
        preset = 1'b0;

        // Write/read in slave 1.
        xfer("wr12", 1'b1, 8'h12, 8'hA5, 8'h00, 1'b0, 4'b0010, LAT);
        xfer("rd12", 1'b0, 8'h12, 8'h00, 8'hA5, 1'b0, 4'b0010, LAT);

        // Reset during the ACCESS of a write to 0x03.
        @(negedge pclk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h03;
        bus.req_wdata = 8'h7E;
        check("rst_accept_ready", 32'(bus.req_ready), 1);
        @(negedge pclk);
        bus.req_valid = 1'b0;
        @(negedge pclk);
        check("rst_in_access", 32'(bus.penable), 1);
        preset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge pclk);
        preset = 1'b0;
        xfer("rd03", 1'b0, 8'h03, 8'h00, 8'h00, 1'b0, 4'b0001, LAT);
        xfer("rd12_cleared", 1'b0, 8'h12, 8'h00, 8'h00, 1'b0, 4'b0010, LAT);

        // Out-of-range decode.
        xfer("wr50", 1'b1, 8'h50, 8'hFF, 8'h00, 1'b1, 4'b0000, 3);
        xfer("rd50", 1'b0, 8'h50, 8'h00, 8'h00, 1'b1, 4'b0000, 3);
        xfer("rd00", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 4'b0001, LAT);
        xfer("rd30", 1'b0, 8'h30, 8'h00, 8'h00, 1'b0, 4'b1000, LAT);

        // Slave isolation.
        xfer("wr05", 1'b1, 8'h05, 8'h11, 8'h00, 1'b0, 4'b0001, LAT);
        xfer("wr15", 1'b1, 8'h15, 8'h22, 8'h00, 1'b0, 4'b0010, LAT);
        xfer("wr25", 1'b1, 8'h25, 8'h33, 8'h00, 1'b0, 4'b0100, LAT);
        xfer("wr35", 1'b1, 8'h35, 8'h44, 8'h00, 1'b0, 4'b1000, LAT);
        xfer("rd05", 1'b0, 8'h05, 8'h00, 8'h11, 1'b0, 4'b0001, LAT);
        xfer("rd15", 1'b0, 8'h15, 8'h00, 8'h22, 1'b0, 4'b0010, LAT);
        xfer("rd25", 1'b0, 8'h25, 8'h00, 8'h33, 1'b0, 4'b0100, LAT);
        xfer("rd35", 1'b0, 8'h35, 8'h00, 8'h44, 1'b0, 4'b1000, LAT);

        // Back-to-back with req_valid held high.
        acc_c = '{0, 0, 0, 0};
        rsp_c = '{0, 0, 0, 0};
        na = 0;
        nr = 0;
        for (int i = 0; i < 60 && nr < 4; i++) begin
            @(negedge pclk);
            if (bus.rsp_valid && nr < 4) begin
                rsp_c[nr] = cyc;
                nr++;
            end
            if (na < 4) begin
                bus.req_valid = 1'b1;
                bus.req_write = 1'b1;
                bus.req_addr  = b2b_addr[na];
                bus.req_wdata = b2b_data[na];
                if (bus.req_ready) begin
                    acc_c[na] = cyc;
                    na++;
                end
            end else begin
                bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        check("b2b_rsp_count", 32'(nr), 4);
        check("b2b_first_lat", 32'(rsp_c[0] - acc_c[0]), 32'(LAT));
        for (int k = 1; k < 4; k++) begin
            check($sformatf("b2b_accept_%0d", k), 32'(acc_c[k]), 32'(rsp_c[k-1]));
            check($sformatf("b2b_spacing_%0d", k), 32'(rsp_c[k] - rsp_c[k-1]), 32'(LAT));
        end
        xfer("rd06", 1'b0, 8'h06, 8'h00, 8'h61, 1'b0, 4'b0001, LAT);
        xfer("rd36", 1'b0, 8'h36, 8'h00, 8'h64, 1'b0, 4'b1000, LAT);

        // Busy hold: second request raised during SETUP.
        @(negedge pclk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h07;
        bus.req_wdata = 8'h5A;
        check("busy_a_ready", 32'(bus.req_ready), 1);
        t_a = cyc;
        @(negedge pclk);
        bus.req_addr  = 8'h17;
        bus.req_wdata = 8'hC3;
        check("busy_ready_setup", 32'(bus.req_ready), 0);
        t_b = 0;
        b_acc = 0;
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge pclk);
            if (bus.rsp_valid) pulses++;
            if (b_acc) bus.req_valid = 1'b0;
            else if (bus.req_ready) begin
                b_acc = 1;
                t_b = cyc;
            end
        end
        bus.req_valid = 1'b0;
        check("busy_b_accepted", 32'(b_acc), 1);
        check("busy_b_accept_cycle", 32'(t_b - t_a), 32'(LAT));
        check("busy_rsp_pulses", 32'(pulses), 2);
        xfer("rd07", 1'b0, 8'h07, 8'h00, 8'h5A, 1'b0, 4'b0001, LAT);
        xfer("rd17", 1'b0, 8'h17, 8'h00, 8'hC3, 1'b0, 4'b0010, LAT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
